// File: rtl/if_fetch_queue.sv
// Fetch decoupling queue: in-order imem req/gnt issue, response pairing with PC, valid/ready to decode.
// Optional same-cycle response forwarding to decode when IF_FETCH_QUEUE_BYPASS_EN is defined.
module if_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [XLEN-1:0]          pc_i,
   input  logic                     pc_valid_i,
   output logic                     pc_ready_o,
   output logic                     imem_req_o,
   output logic [XLEN-1:0]          imem_addr_o,
   input  logic                     imem_gnt_i,
   input  logic                     imem_rvalid_i,
   input  logic [XLEN-1:0]          imem_rdata_i,
   input  logic                     flush_i,
   output logic                     dec_valid_o,
   input  logic                     dec_ready_i,
   output logic [XLEN-1:0]          dec_pc_o,
   output logic [XLEN-1:0]          dec_instr_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam logic [PW:0]   L_DEPTH = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] L_ONE   = {{(PW-1){1'b0}}, 1'b1};

   logic [PW-1:0]   r_alloc_ptr;
   logic [PW-1:0]   r_fill_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_drop_cnt;
   logic [XLEN-1:0] r_pc_mem    [DEPTH];
   logic [XLEN-1:0] r_instr_mem [DEPTH];

   logic [IW-1:0]   w_alloc_idx;
   logic [IW-1:0]   w_fill_idx;
   logic [IW-1:0]   w_rd_idx;
   logic [PW-1:0]   w_outstanding;
   logic [PW-1:0]   w_used;
   logic [PW:0]     w_credit;
   logic            w_credit_ok;
   logic            w_issue;
   logic            w_fill;
   logic            w_drop;
   logic            w_pop;
   logic            w_head_valid;
   logic [PW-1:0]   w_drop_sum;
   logic [PW-1:0]   w_drop_flush;
   logic            w_dec_valid;
   logic [XLEN-1:0] w_dec_pc;
   logic [XLEN-1:0] w_dec_instr;

   assign w_alloc_idx   = r_alloc_ptr[IW-1:0];
   assign w_fill_idx    = r_fill_ptr[IW-1:0];
   assign w_rd_idx      = r_rd_ptr[IW-1:0];
   assign w_outstanding = r_alloc_ptr - r_fill_ptr;
   assign w_used        = r_alloc_ptr - r_rd_ptr;

   // Responses still owed for flushed requests keep holding their slot's credit.
   assign w_credit    = L_DEPTH - {1'b0, w_used} - {1'b0, r_drop_cnt};
   assign w_credit_ok = ~w_credit[PW] & (w_credit != '0);

   assign imem_req_o  = pc_valid_i & w_credit_ok & ~flush_i & ~rst;
   assign imem_addr_o = pc_i;
   assign w_issue     = imem_req_o & imem_gnt_i;
   assign pc_ready_o  = w_issue;

   assign w_fill       = imem_rvalid_i & (r_drop_cnt == '0) & (w_outstanding != '0);
   assign w_drop       = imem_rvalid_i & (r_drop_cnt != '0);
   assign w_head_valid = (r_fill_ptr != r_rd_ptr);

   // An rvalid landing in the flush cycle belongs to the pre-flush stream.
   assign w_drop_sum   = r_drop_cnt + w_outstanding;
   assign w_drop_flush = (w_drop_sum == '0) ? '0
                       : (w_drop_sum - {{(PW-1){1'b0}}, imem_rvalid_i});

`ifdef IF_FETCH_QUEUE_BYPASS_EN
   logic w_bypass;
   assign w_bypass    = ~w_head_valid & w_fill & ~flush_i & ~rst;
   assign w_dec_valid = (w_head_valid | w_bypass) & ~flush_i & ~rst;
   assign w_dec_pc    = w_bypass ? r_pc_mem[w_fill_idx] : r_pc_mem[w_rd_idx];
   assign w_dec_instr = w_bypass ? imem_rdata_i : r_instr_mem[w_rd_idx];
`else
   assign w_dec_valid = w_head_valid & ~flush_i & ~rst;
   assign w_dec_pc    = r_pc_mem[w_rd_idx];
   assign w_dec_instr = r_instr_mem[w_rd_idx];
`endif

   assign w_pop       = w_dec_valid & dec_ready_i;
   assign dec_valid_o = w_dec_valid;
   assign dec_pc_o    = rst ? '0 : w_dec_pc;
   assign dec_instr_o = rst ? '0 : w_dec_instr;
   assign count_o     = rst ? '0 : w_used;

   // Pointer and drop-counter state; flush wins over issue, fill and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_rd_ptr    <= '0;
         r_drop_cnt  <= '0;
      end else if (flush_i) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_rd_ptr    <= '0;
         r_drop_cnt  <= w_drop_flush;
      end else begin
         if (w_issue) begin
            r_alloc_ptr <= r_alloc_ptr + L_ONE;
         end
         if (w_fill) begin
            r_fill_ptr <= r_fill_ptr + L_ONE;
         end
         if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - L_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + L_ONE;
         end
      end
   end

   // Entry storage: PC captured at grant, instruction captured at fill.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && w_issue) begin
         r_pc_mem[w_alloc_idx] <= pc_i;
      end
      if (!rst && !flush_i && w_fill) begin
         r_instr_mem[w_fill_idx] <= imem_rdata_i;
      end
   end

   a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
      imem_rvalid_i |-> ((r_drop_cnt != '0) || (w_outstanding != '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: inputs driven after posedge, outputs checked mid-cycle.
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i = 32'h0;
   logic        pc_valid_i = 1'b0;
   logic        pc_ready_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        flush_i = 1'b0;
   logic        dec_valid_o;
   logic        dec_ready_i = 1'b0;
   logic [31:0] dec_pc_o;
   logic [31:0] dec_instr_o;
   logic [2:0]  count_o;

   int n_cmp = 0;
   int n_bad = 0;
   int grants = 0;

   if_fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .flush_i(flush_i),
      .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_pc_o(dec_pc_o),
      .dec_instr_o(dec_instr_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dec(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
      check_eq({tag, "_valid"}, {31'h0, dec_valid_o}, {31'h0, v});
      if (v) begin
         check_eq({tag, "_pc"}, dec_pc_o, pc);
         check_eq({tag, "_instr"}, dec_instr_o, ins);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [2:0] c);
      check_eq({tag, "_count"}, {29'h0, count_o}, {29'h0, c});
   endtask

   task automatic chk_rdy(input string tag, input logic r);
      check_eq({tag, "_pc_ready"}, {31'h0, pc_ready_o}, {31'h0, r});
   endtask

   task automatic drv(input logic pcv, input logic [31:0] pc, input logic gnt, input logic rv,
                      input logic [31:0] rd, input logic fl, input logic dr);
      pc_valid_i    = pcv;
      pc_i          = pc;
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rd;
      flush_i       = fl;
      dec_ready_i   = dr;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk); #1;
      // reset state, even with a PC offered
      drv(1'b1, 32'h0000_0ABC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("rst_req", {31'h0, imem_req_o}, 32'h0);
      chk_rdy("rst", 1'b0);
      chk_dec("rst", 1'b0, 32'h0, 32'h0);
      check_eq("rst_dec_pc", dec_pc_o, 32'h0);
      check_eq("rst_dec_instr", dec_instr_o, 32'h0);
      chk_cnt("rst", 3'd0);
      tick();
      rst = 1'b0;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
      // forwarding with decode ready: visible the cycle of rvalid, nothing buffered
      drv(1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); chk_rdy("byp0", 1'b1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0080, 1'b0, 1'b1);
      chk_dec("byp1", 1'b1, 32'h80, 32'hD000_0080); chk_cnt("byp1", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("byp2", 1'b0, 32'h0, 32'h0); chk_cnt("byp2", 3'd0); tick();
      // forwarding with decode stalled: entry buffered and held
      drv(1'b1, 32'h84, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0084, 1'b0, 1'b0);
      chk_dec("byp3", 1'b1, 32'h84, 32'hD000_0084); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("byp4", 1'b1, 32'h84, 32'hD000_0084); chk_cnt("byp4", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("byp5", 1'b0, 32'h0, 32'h0); chk_cnt("byp5", 3'd0); tick();
`else
      // streaming: decode sees entries from gnt+2, one per cycle
      drv(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("s0_req", {31'h0, imem_req_o}, 32'h1); chk_rdy("s0", 1'b1);
      check_eq("s0_addr", imem_addr_o, 32'h0); chk_dec("s0", 1'b0, 32'h0, 32'h0); chk_cnt("s0", 3'd0); tick();
      drv(1'b1, 32'h4, 1'b1, 1'b1, 32'hD000_0000, 1'b0, 1'b1);
      chk_dec("s1", 1'b0, 32'h0, 32'h0); chk_cnt("s1", 3'd1); tick();
      drv(1'b1, 32'h8, 1'b1, 1'b1, 32'hD000_0004, 1'b0, 1'b1);
      chk_dec("s2", 1'b1, 32'h0, 32'hD000_0000); chk_cnt("s2", 3'd2); tick();
      drv(1'b1, 32'hC, 1'b1, 1'b1, 32'hD000_0008, 1'b0, 1'b1);
      chk_dec("s3", 1'b1, 32'h4, 32'hD000_0004); chk_cnt("s3", 3'd2);
      check_eq("s3_addr", imem_addr_o, 32'hC); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_000C, 1'b0, 1'b1);
      chk_dec("s4", 1'b1, 32'h8, 32'hD000_0008); chk_cnt("s4", 3'd2);
      check_eq("s4_req", {31'h0, imem_req_o}, 32'h0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("s5", 1'b1, 32'hC, 32'hD000_000C); chk_cnt("s5", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("s6", 1'b0, 32'h0, 32'h0); chk_cnt("s6", 3'd0); tick();

      // full: decode stalled, PCs 0x10.. offered, only four granted
      drv(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); grants += int'(pc_ready_o); tick();
      drv(1'b1, 32'h14, 1'b1, 1'b1, 32'hD000_0010, 1'b0, 1'b0); grants += int'(pc_ready_o); tick();
      drv(1'b1, 32'h18, 1'b1, 1'b1, 32'hD000_0014, 1'b0, 1'b0); grants += int'(pc_ready_o); tick();
      drv(1'b1, 32'h1C, 1'b1, 1'b1, 32'hD000_0018, 1'b0, 1'b0); grants += int'(pc_ready_o);
      chk_cnt("f3", 3'd3); tick();
      drv(1'b1, 32'h20, 1'b1, 1'b1, 32'hD000_001C, 1'b0, 1'b0); grants += int'(pc_ready_o);
      check_eq("f4_req", {31'h0, imem_req_o}, 32'h0); chk_cnt("f4", 3'd4);
      chk_dec("f4", 1'b1, 32'h10, 32'hD000_0010); tick();
      drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); grants += int'(pc_ready_o);
      chk_rdy("f5", 1'b0); chk_cnt("f5", 3'd4); tick();
      check_eq("full_grants", grants, 32'd4);
      // release decode: drain in order, issue resumes
      drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_rdy("e0", 1'b0); chk_dec("e0", 1'b1, 32'h10, 32'hD000_0010); chk_cnt("e0", 3'd4); tick();
      drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_rdy("e1", 1'b1); chk_dec("e1", 1'b1, 32'h14, 32'hD000_0014); chk_cnt("e1", 3'd3); tick();
      drv(1'b1, 32'h24, 1'b1, 1'b1, 32'hD000_0020, 1'b0, 1'b1);
      chk_rdy("e2", 1'b1); chk_dec("e2", 1'b1, 32'h18, 32'hD000_0018); chk_cnt("e2", 3'd3); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0024, 1'b0, 1'b1);
      chk_dec("e3", 1'b1, 32'h1C, 32'hD000_001C); chk_cnt("e3", 3'd3); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("e4", 1'b1, 32'h20, 32'hD000_0020); chk_cnt("e4", 3'd2); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("e5", 1'b1, 32'h24, 32'hD000_0024); chk_cnt("e5", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("e6", 1'b0, 32'h0, 32'h0); chk_cnt("e6", 3'd0); tick();

      // flush with two in flight and one buffered
      drv(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
      drv(1'b1, 32'h44, 1'b1, 1'b1, 32'hD000_0040, 1'b0, 1'b0); tick();
      drv(1'b1, 32'h48, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_dec("fl2", 1'b1, 32'h40, 32'hD000_0040); tick();
      drv(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      check_eq("fl3_req", {31'h0, imem_req_o}, 32'h0); chk_rdy("fl3", 1'b0);
      chk_dec("fl3", 1'b0, 32'h0, 32'h0); tick();
      drv(1'b1, 32'h100, 1'b1, 1'b1, 32'hD000_0044, 1'b0, 1'b0);
      chk_rdy("fl4", 1'b1); chk_dec("fl4", 1'b0, 32'h0, 32'h0); chk_cnt("fl4", 3'd0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0048, 1'b0, 1'b0);
      chk_dec("fl5", 1'b0, 32'h0, 32'h0); chk_cnt("fl5", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0100, 1'b0, 1'b0);
      chk_dec("fl6", 1'b0, 32'h0, 32'h0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("fl7", 1'b1, 32'h100, 32'hD000_0100); chk_cnt("fl7", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("fl8", 1'b0, 32'h0, 32'h0); chk_cnt("fl8", 3'd0); tick();

      // flush coinciding with rvalid, three in flight: two more responses dropped
      drv(1'b1, 32'h50, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
      drv(1'b1, 32'h54, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
      drv(1'b1, 32'h58, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); chk_cnt("g2", 3'd2); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0050, 1'b1, 1'b0);
      chk_dec("g3", 1'b0, 32'h0, 32'h0); tick();
      drv(1'b1, 32'h200, 1'b1, 1'b1, 32'hD000_0054, 1'b0, 1'b0);
      chk_rdy("g4", 1'b1); chk_dec("g4", 1'b0, 32'h0, 32'h0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0058, 1'b0, 1'b0);
      chk_dec("g5", 1'b0, 32'h0, 32'h0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0200, 1'b0, 1'b0);
      chk_dec("g6", 1'b0, 32'h0, 32'h0); chk_cnt("g6", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("g7", 1'b1, 32'h200, 32'hD000_0200); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("g8", 1'b0, 32'h0, 32'h0); chk_cnt("g8", 3'd0); tick();

      // reset mid-stream with two buffered
      drv(1'b1, 32'h60, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
      drv(1'b1, 32'h64, 1'b1, 1'b1, 32'hD000_0060, 1'b0, 1'b0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0064, 1'b0, 1'b0);
      chk_dec("h2", 1'b1, 32'h60, 32'hD000_0060); chk_cnt("h2", 3'd2); tick();
      rst = 1'b1;
      drv(1'b1, 32'h68, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("h3_req", {31'h0, imem_req_o}, 32'h0); chk_dec("h3", 1'b0, 32'h0, 32'h0);
      chk_cnt("h3", 3'd0); tick();
      rst = 1'b0;
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("h4_req", {31'h0, imem_req_o}, 32'h0); chk_dec("h4", 1'b0, 32'h0, 32'h0);
      chk_cnt("h4", 3'd0); tick();
      drv(1'b1, 32'h70, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_rdy("h5", 1'b1); chk_cnt("h5", 3'd0); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0070, 1'b0, 1'b0);
      chk_dec("h6", 1'b0, 32'h0, 32'h0); chk_cnt("h6", 3'd1); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_dec("h7", 1'b1, 32'h70, 32'hD000_0070); tick();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_cnt("h8", 3'd0); tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
